// File: rtl/spike_rate_encoder_pkg.sv
// Shared types, constants and seed derivation for the rate-coded spike encoder.
// Imported by the encoder top and its per-channel LFSR.
package spike_rate_encoder_pkg;

  localparam int          ENC_PIX_W     = 8;
  localparam logic [15:0] ENC_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] ENC_SEED_MUL  = 16'h1F35;

  typedef logic [ENC_PIX_W-1:0] pixel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } enc_state_e;

  typedef enum logic {
    ENC_ACC  = 1'b0,
    ENC_LFSR = 1'b1
  } enc_mode_e;

  // Per-channel seed; an all-zero Galois LFSR would lock up, so 0 maps to 1.
  function automatic logic [15:0] enc_seed(input logic [15:0] base, input int unsigned ch);
    logic [15:0] s;
    s = base ^ 16'((ch + 1) * ENC_SEED_MUL);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/spike_lfsr.sv
// 16-bit right-shifting Galois LFSR with a reset seed and an advance enable.
// One instance per encoder channel supplies the stochastic comparison value.
module spike_lfsr
  import spike_rate_encoder_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] value
);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (advance) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? ENC_LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: accepts one multi-channel pixel sample, then emits WINDOW timesteps
// of spike pulses per channel using either a phase accumulator or an LFSR comparator.
module spike_rate_encoder
  import spike_rate_encoder_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          PIX_W     = 8,
  parameter int          WINDOW    = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    mode,
  input  logic                    abort,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [NUM_CH*PIX_W-1:0] pix_data,
  output logic [NUM_CH-1:0]       spike_out,
  output logic                    window_done,
  output logic                    busy
);

  localparam int               CNT_W     = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WINDOW - 1);

  enc_state_e       state;
  enc_mode_e        mode_q;
  logic [CNT_W-1:0] step_cnt;
  logic [PIX_W-1:0] pix_q    [NUM_CH];
  logic [PIX_W-1:0] acc      [NUM_CH];
  logic [PIX_W-1:0] lfsr_low [NUM_CH];
  logic [PIX_W:0]   sum      [NUM_CH];
  logic [NUM_CH-1:0] spike_next;
  logic             step;
  logic             lfsr_adv;

  assign pix_ready = (state == IDLE);
  assign busy      = (state == ENCODE);

  // abort wins over tick, so an aborted cycle is never a step.
  assign step     = (state == ENCODE) && tick && !abort;
  // The LFSR sequence runs only on stochastic steps and continues across samples.
  assign lfsr_adv = step && (mode_q == ENC_LFSR);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [15:0]      lfsr_value;
    logic [15-PIX_W:0] lfsr_unused_hi;

    spike_lfsr #(
      .SEED(enc_seed(LFSR_SEED, c))
    ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .advance(lfsr_adv),
      .value  (lfsr_value)
    );

    assign lfsr_low[c]    = lfsr_value[PIX_W-1:0];
    assign lfsr_unused_hi = lfsr_value[15:PIX_W];
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c]        = {1'b0, acc[c]} + {1'b0, pix_q[c]};
      spike_next[c] = (mode_q == ENC_ACC) ? sum[c][PIX_W] : (lfsr_low[c] < pix_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= ENC_ACC;
      step_cnt    <= '0;
      spike_out   <= '0;
      window_done <= 1'b0;
      // NOTE: these arrays are a handful of flops, not a RAM, so resetting them
      // is cheap and keeps post-reset behaviour fully defined.
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]   <= '0;
        pix_q[c] <= '0;
      end
    end else begin
      // NOTE: pulse outputs default low each cycle; only a step raises them.
      spike_out   <= '0;
      window_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pix_valid) begin
            state    <= ENCODE;
            mode_q   <= enc_mode_e'(mode);
            step_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              acc[c]   <= '0;
              pix_q[c] <= pix_data[c*PIX_W +: PIX_W];
            end
          end
        end
        ENCODE: begin
          if (abort) begin
            state <= IDLE;
          end else if (tick) begin
            spike_out <= spike_next;
            if (mode_q == ENC_ACC) begin
              for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= sum[c][PIX_W-1:0];
              end
            end
            if (step_cnt == LAST_STEP) begin
              window_done <= 1'b1;
              state       <= IDLE;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: a window-level reference model predicts
// every cycle's outputs, and a separate monitor compares them against the DUT.
module tb_spike_rate_encoder;
  import spike_rate_encoder_pkg::*;

  localparam int NUM_CH = 4;
  localparam int PIX_W  = 8;
  localparam int WINDOW = 64;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    tick = 1'b0;
  logic                    mode = 1'b0;
  logic                    abort = 1'b0;
  logic                    pix_valid = 1'b0;
  logic                    pix_ready;
  logic [NUM_CH*PIX_W-1:0] pix_data = '0;
  logic [NUM_CH-1:0]       spike_out;
  logic                    window_done;
  logic                    busy;

  spike_rate_encoder #(
    .NUM_CH   (NUM_CH),
    .PIX_W    (PIX_W),
    .WINDOW   (WINDOW),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .mode       (mode),
    .abort      (abort),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .spike_out  (spike_out),
    .window_done(window_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] spike;
    logic              done;
    logic              ready;
    logic              busy;
    logic              step;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] obs[$];
  logic [3:0] w1[$];
  logic [3:0] w2[$];
  int         checks = 0;
  int         errors = 0;
  int         spk_cnt[NUM_CH];
  int         done_cnt;

  // Reference model state: window position, latched sample, per-channel LFSR value.
  bit          m_busy;
  bit          m_lfsr_mode;
  int          m_step;
  pixel_t      m_pix[NUM_CH];
  logic [15:0] m_lfsr[NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [31:0] pack4(input int p0, input int p1, input int p2, input int p3);
    return {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
  endfunction

  task automatic model_reset();
    logic [15:0] s;
    m_busy = 1'b0;
    m_step = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      s = 16'hACE1 ^ 16'((c + 1) * 32'h1F35);
      m_lfsr[c] = (s == 16'h0000) ? 16'h0001 : s;
    end
  endtask

  // Spike k of a window (k = 1..WINDOW) in accumulator mode fires when
  // floor(k*pix/256) steps up; the window total is then floor(WINDOW*pix/256).
  task automatic model_cycle(input bit t, input bit v, input bit a, input bit md,
                             input logic [31:0] d, output exp_t e);
    int p;
    e = '0;
    if (!m_busy) begin
      if (v) begin
        m_busy      = 1'b1;
        m_lfsr_mode = md;
        m_step      = 0;
        for (int c = 0; c < NUM_CH; c++) m_pix[c] = d[c*PIX_W +: PIX_W];
      end
    end else if (a) begin
      m_busy = 1'b0;
    end else if (t) begin
      e.step = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        p = int'(m_pix[c]);
        if (!m_lfsr_mode) begin
          e.spike[c] = (((m_step + 1) * p) / 256) != ((m_step * p) / 256);
        end else begin
          e.spike[c] = (m_lfsr[c][7:0] < m_pix[c]);
          m_lfsr[c]  = lfsr_next(m_lfsr[c]);
        end
      end
      m_step++;
      if (m_step == WINDOW) begin
        e.done = 1'b1;
        m_busy = 1'b0;
      end
    end
    e.ready = !m_busy;
    e.busy  = m_busy;
  endtask

  task automatic cyc(input bit t, input bit v, input bit a, input bit md, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    tick      = t;
    pix_valid = v;
    abort     = a;
    mode      = md;
    pix_data  = d;
    model_cycle(t, v, a, md, d, e);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    idle(2);
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NUM_CH; c++) spk_cnt[c] = 0;
    done_cnt = 0;
    obs.delete();
  endtask

  task automatic run_window(input bit md, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, md, d);
    repeat (WINDOW) cyc(1'b1, 1'b0, 1'b0, md, '0);
  endtask

  // Monitor: one expected record per clock, compared just after the edge.
  initial begin : monitor
    exp_t me;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        me = sb.pop_front();
        check("cycle_outputs", {24'h0, spike_out, window_done, pix_ready, busy},
              {24'h0, me.spike, me.done, me.ready, me.busy});
        if (me.step) obs.push_back(spike_out);
        for (int c = 0; c < NUM_CH; c++) spk_cnt[c] += int'(spike_out[c]);
        done_cnt += int'(window_done);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int diff;
    int acc_exp[NUM_CH];
    model_reset();
    #12;
    check("reset_spike", spike_out, 0);
    check("reset_done", window_done, 0);
    check("reset_ready", pix_ready, 1);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Accumulator mode, tick every cycle.
    clear_counts();
    run_window(1'b0, pack4(0, 64, 128, 255));
    drain();
    acc_exp = '{0, 16, 32, 63};
    for (int c = 0; c < NUM_CH; c++) check($sformatf("t1_count_ch%0d", c), spk_cnt[c], acc_exp[c]);
    check("t1_done_count", done_cnt, 1);

    // Sparse ticks: one tick every third cycle.
    clear_counts();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, pack4(128, 128, 128, 128));
    repeat (WINDOW) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      idle(2);
    end
    drain();
    for (int c = 0; c < NUM_CH; c++) check($sformatf("t2_count_ch%0d", c), spk_cnt[c], 32);
    check("t2_done_count", done_cnt, 1);

    // Back-to-back with pix_valid held high; second sample taken on window_done.
    clear_counts();
    repeat (WINDOW + 1) cyc(1'b1, 1'b1, 1'b0, 1'b0, pack4(64, 64, 64, 64));
    repeat (WINDOW + 1) cyc(1'b1, 1'b1, 1'b0, 1'b0, pack4(255, 1, 200, 7));
    drain();
    acc_exp = '{79, 16, 66, 17};
    for (int c = 0; c < NUM_CH; c++) check($sformatf("t3_count_ch%0d", c), spk_cnt[c], acc_exp[c]);
    check("t3_done_count", done_cnt, 2);

    // Abort at step 20 together with a tick, then a fresh sample.
    clear_counts();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, pack4(200, 200, 200, 200));
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    drain();
    check("t4_abort_no_done", done_cnt, 0);
    clear_counts();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, pack4(64, 64, 64, 64));
    repeat (WINDOW) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drain();
    for (int c = 0; c < NUM_CH; c++) check($sformatf("t4_count_ch%0d", c), spk_cnt[c], 16);
    check("t4_done_count", done_cnt, 1);

    // LFSR mode: two consecutive windows must differ (no reseed).
    clear_counts();
    run_window(1'b1, pack4(128, 0, 128, 200));
    drain();
    w1 = obs;
    check("t5_zero_channel", spk_cnt[1], 0);
    check("t5_step_count", obs.size(), WINDOW);
    clear_counts();
    run_window(1'b1, pack4(128, 0, 128, 200));
    drain();
    w2 = obs;
    diff = 0;
    for (int i = 0; i < WINDOW; i++) diff += int'(w1[i] != w2[i]);
    check("t5_windows_differ", diff != 0, 1);

    // Reset at step 30 of an LFSR window, then replay the first LFSR window.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, pack4(128, 0, 128, 200));
    repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check("t6_async_spike", spike_out, 0);
    check("t6_async_done", window_done, 0);
    check("t6_async_ready", pix_ready, 1);
    check("t6_async_busy", busy, 0);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    run_window(1'b1, pack4(128, 0, 128, 200));
    drain();
    diff = 0;
    for (int i = 0; i < WINDOW; i++) diff += int'(obs[i] != w1[i]);
    check("t6_lfsr_restart", diff, 0);

    // Randomized traffic against the model.
    repeat (600) begin
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
          1'($urandom_range(0, 1)), $urandom);
    end
    drain();
    check("random_queue_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Converts multi-channel pixel intensities into rate-coded spike trains that drive the input_spike pins of the lif_neuron array.
- Sits between the input-sample buffer (valid/ready source) and the neuron layer.
- One sample is accepted, encoded over a fixed window of WINDOW timesteps, then the next sample is accepted.
- Two modes: deterministic phase-accumulator encoding, and stochastic LFSR-comparator encoding.

Parameters:
- NUM_CH, 4: number of pixel channels and spike outputs.
- PIX_W, 8: pixel intensity width, unsigned.
- WINDOW, 64: timesteps per sample; legal range 2..65535.
- LFSR_SEED, 16'hACE1: base seed for the stochastic-mode LFSRs.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  global timestep strobe; one encode step per cycle with tick=1
- mode  in  1  0 = accumulator, 1 = LFSR; sampled at handshake
- abort  in  1  synchronous cancel of the current window
- pix_valid  in  1  sample valid
- pix_ready  out  1  encoder can accept a sample
- pix_data  in  NUM_CH*PIX_W  channel c occupies bits [c*PIX_W +: PIX_W]
- spike_out  out  NUM_CH  one-cycle spike pulses, one per channel
- window_done  out  1  one-cycle pulse coinciding with the last step's spike_out
- busy  out  1  high while in ENCODE

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - state = IDLE; spike_out = 0; window_done = 0; busy = 0; pix_ready = 1.
  - Accumulators = 0; step_cnt = 0; LFSRs = their per-channel seeds.
- State machine, two states: IDLE and ENCODE.
- IDLE:
  - pix_ready = 1 (combinational, from state).
  - On pix_valid & pix_ready: latch pix_data and mode, clear accumulators and step_cnt, go to ENCODE.
  - tick is ignored in IDLE.
- ENCODE:
  - pix_ready = 0; busy = 1.
  - Each cycle with tick=1 is one step.
  - On the step where step_cnt == WINDOW-1: window_done <= 1, go to IDLE.
  - Cycles without tick hold all state, and spike_out <= 0.
- Latency:
  - First possible step is on the cycle after the handshake.
  - spike_out is registered and is high the cycle after the tick that produced it.
- Accumulator mode, per channel:
  - sum = {1'b0, acc} + pix, PIX_W+1 bits.
  - spike = sum[PIX_W]; acc <= sum[PIX_W-1:0].
  - Spike count over a window = floor(WINDOW*pix / 2^PIX_W), exact.
- LFSR mode, per channel:
  - 16-bit Galois LFSR, taps 16'hB400, advanced once per step (ENCODE only).
  - spike = (lfsr[PIX_W-1:0] < pix), evaluated on the pre-advance value.
  - Channel seed = LFSR_SEED ^ ((c+1) * 16'h1F35); if the result is 0, use 16'h0001.
  - LFSRs are not reseeded per window; the sequence continues across samples. Only rst_n restores the seeds.
- Boundary values:
  - pix = 0 never spikes in either mode.
  - pix = 2^PIX_W-1 in accumulator mode gives WINDOW-1 spikes when WINDOW <= 2^PIX_W.
- Abort:
  - abort=1 in ENCODE: go to IDLE, spike_out <= 0, no window_done.
  - abort takes priority over tick in the same cycle.
  - abort in IDLE has no effect and does not block a same-cycle handshake.
- Back-to-back samples: pix_ready returns high in the same cycle that window_done is high, so the next handshake can occur that cycle.
- Reset mid-window: immediate return to reset values; no residual spikes.
- step_cnt width is $clog2(WINDOW); it does not wrap within a window.

Decomposition:
- neuron_pkg additions:
  - pixel_t (logic [PIX_W-1:0])
  - ENC_LFSR_TAPS = 16'hB400
  - ENC_SEED_MUL = 16'h1F35
  - enc_state_e {IDLE, ENCODE}
  - enc_mode_e {ENC_ACC, ENC_LFSR}
- Sub-module spike_lfsr: one 16-bit Galois LFSR with seed parameter, advance enable and state output. Instantiated NUM_CH times via generate.

Test Plan:
1. Accumulator mode, pix = {0, 64, 128, 255}, WINDOW=64, tick every cycle:
   - Spike counts = {0, 16, 32, 63}.
   - ch1 spikes on steps 4, 8, 12, …; ch2 spikes on every 2nd step.
   - window_done appears exactly once, with the 64th step's spike_out.
2. Sparse ticks: tick every 3rd cycle, pix = 128.
   - 32 spikes; spike_out is only ever high the cycle after a tick.
   - window_done arrives 64 ticks after the handshake.
3. Handshake and back-to-back:
   - pix_valid held high: pix_ready=0 throughout ENCODE.
   - Second sample accepted in the cycle window_done=1; its first step starts next cycle.
4. Abort at step 20 with tick=1 in the same cycle:
   - No spike_out, no window_done, pix_ready=1 next cycle.
   - New sample with pix=64 then yields exactly 16 spikes (accumulators cleared).
5. LFSR mode, pix = 128, WINDOW=64:
   - Per-step spikes match a reference model using the specified seeds and taps.
   - pix=0 channel gives 0 spikes.
   - Two consecutive windows give different patterns (no reseed).
6. rst_n asserted mid-ENCODE (step 30):
   - All outputs return to reset values asynchronously.
   - After release, the LFSR sequence restarts from its seeds and matches test 5 from step 0.
